// File: rtl/mxint_sched_pkg.sv
// Shared sizing helpers and types for the MXINT dot-product scheduler.
package mxint_sched_pkg;

    localparam int NUM_REQ_DEF = 4;

    // Tag width for a requester index; at least one bit so single-channel builds still elaborate.
    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold 0..m inclusive.
    function automatic int occ_w(input int m);
        return $clog2(m + 1);
    endfunction

    localparam int TAG_W_DEF = tag_w(NUM_REQ_DEF);

    typedef logic [TAG_W_DEF-1:0] tag_t;

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, head visible combinationally; push+pop honoured when full.
// Latency 1 cycle push->head; pops while empty and pushes while full (without pop) are dropped.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_dat,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_dat,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  w_pop_en;
    logic                  w_push_en;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop_en   = i_pop && !o_empty;
    assign w_push_en  = i_push && (!o_full || w_pop_en);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_en) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
    end

endmodule

// File: rtl/mxint_rr_arbiter.sv
// Round-robin arbiter: first requester at or after the pointer wins; purely combinational.
// Zero latency; grants nothing while disabled.
module mxint_rr_arbiter
    import mxint_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int TAG_W  = tag_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_en,
    input  logic [TAG_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [TAG_W-1:0]   o_grant_idx
);
    logic [TAG_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = TAG_W'((int'(i_ptr) + i) % NUM_REQ);
            if (i_en && !w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/mxint_dot_product_scheduler.sv
// Round-robin share of one MXINT dot-product unit; in-order tags route results back to owners.
// Latency 1 cycle req->dp; one holding register, credit cap MAX_INFLIGHT, head-of-line blocking on returns.
module mxint_dot_product_scheduler
    import mxint_sched_pkg::*;
#(
    parameter int NUM_REQ                = 4,
    parameter int BLOCK_SIZE             = 6,
    parameter int DATA_IN_0_PRECISION_0  = 8,
    parameter int DATA_IN_0_PRECISION_1  = 8,
    parameter int WEIGHT_PRECISION_0     = 8,
    parameter int WEIGHT_PRECISION_1     = 8,
    parameter int DATA_OUT_0_PRECISION_0 = DATA_IN_0_PRECISION_0 + WEIGHT_PRECISION_0 + $clog2(BLOCK_SIZE),
    parameter int DATA_OUT_0_PRECISION_1 = ((DATA_IN_0_PRECISION_1 > WEIGHT_PRECISION_1) ?
                                            DATA_IN_0_PRECISION_1 : WEIGHT_PRECISION_1) + 1,
    parameter int MAX_INFLIGHT           = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_IN_0_PRECISION_0-1:0]  req_mdata   [NUM_REQ*BLOCK_SIZE],
    input  logic [DATA_IN_0_PRECISION_1-1:0]  req_edata   [NUM_REQ],
    input  logic [WEIGHT_PRECISION_0-1:0]     req_mweight [NUM_REQ*BLOCK_SIZE],
    input  logic [WEIGHT_PRECISION_1-1:0]     req_eweight [NUM_REQ],
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [DATA_IN_0_PRECISION_0-1:0]  dp_mdata    [BLOCK_SIZE],
    output logic [DATA_IN_0_PRECISION_1-1:0]  dp_edata,
    output logic [WEIGHT_PRECISION_0-1:0]     dp_mweight  [BLOCK_SIZE],
    output logic [WEIGHT_PRECISION_1-1:0]     dp_eweight,
    output logic                              dp_data_valid,
    output logic                              dp_weight_valid,
    input  logic                              dp_data_ready,
    input  logic                              dp_weight_ready,
    input  logic [DATA_OUT_0_PRECISION_0-1:0] dp_mresult,
    input  logic [DATA_OUT_0_PRECISION_1-1:0] dp_eresult,
    input  logic                              dp_result_valid,
    output logic                              dp_result_ready,
    output logic [DATA_OUT_0_PRECISION_0-1:0] res_mdata,
    output logic [DATA_OUT_0_PRECISION_1-1:0] res_edata,
    output logic [NUM_REQ-1:0]                res_valid,
    input  logic [NUM_REQ-1:0]                res_ready,
    output logic [occ_w(MAX_INFLIGHT)-1:0]    inflight,
    output logic                              err
);
    localparam int TAG_W = tag_w(NUM_REQ);
    localparam int OCC_W = occ_w(MAX_INFLIGHT);

    logic                             r_hr_valid;
    logic [TAG_W-1:0]                 r_hr_tag;
    logic [DATA_IN_0_PRECISION_0-1:0] r_hr_mdata   [BLOCK_SIZE];
    logic [DATA_IN_0_PRECISION_1-1:0] r_hr_edata;
    logic [WEIGHT_PRECISION_0-1:0]    r_hr_mweight [BLOCK_SIZE];
    logic [WEIGHT_PRECISION_1-1:0]    r_hr_eweight;
    logic [TAG_W-1:0]                 r_ptr;
    logic [OCC_W-1:0]                 r_inflight;
    logic                             r_err;

    logic                             w_dp_accept;
    logic                             w_can_accept;
    logic [NUM_REQ-1:0]               w_grant;
    logic [TAG_W-1:0]                 w_grant_idx;
    logic                             w_req_hs;
    logic                             w_res_hs;
    logic [TAG_W-1:0]                 w_head_tag;
    logic                             w_fifo_full;
    logic                             w_fifo_empty;
    logic [DATA_IN_0_PRECISION_0-1:0] w_sel_mdata   [BLOCK_SIZE];
    logic [DATA_IN_0_PRECISION_1-1:0] w_sel_edata;
    logic [WEIGHT_PRECISION_0-1:0]    w_sel_mweight [BLOCK_SIZE];
    logic [WEIGHT_PRECISION_1-1:0]    w_sel_eweight;

    assign w_dp_accept  = r_hr_valid && dp_data_ready && dp_weight_ready;
    // Gated by rst so the combinational ready stays low while the block is held in reset.
    assign w_can_accept = rst && (!r_hr_valid || w_dp_accept) && (r_inflight < OCC_W'(MAX_INFLIGHT));
    assign w_req_hs     = |w_grant;
    assign req_ready    = w_grant;

    mxint_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req       (req_valid),
        .i_en        (w_can_accept),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    always_comb begin
        w_sel_edata   = '0;
        w_sel_eweight = '0;
        for (int j = 0; j < BLOCK_SIZE; j++) begin
            w_sel_mdata[j]   = '0;
            w_sel_mweight[j] = '0;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_grant[r]) begin
                w_sel_edata   = req_edata[r];
                w_sel_eweight = req_eweight[r];
                for (int j = 0; j < BLOCK_SIZE; j++) begin
                    w_sel_mdata[j]   = req_mdata[r*BLOCK_SIZE+j];
                    w_sel_mweight[j] = req_mweight[r*BLOCK_SIZE+j];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hr_valid   <= 1'b0;
            r_hr_tag     <= '0;
            r_hr_edata   <= '0;
            r_hr_eweight <= '0;
            for (int j = 0; j < BLOCK_SIZE; j++) begin
                r_hr_mdata[j]   <= '0;
                r_hr_mweight[j] <= '0;
            end
            r_ptr      <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_req_hs) begin
                r_hr_valid   <= 1'b1;
                r_hr_tag     <= w_grant_idx;
                r_hr_mdata   <= w_sel_mdata;
                r_hr_edata   <= w_sel_edata;
                r_hr_mweight <= w_sel_mweight;
                r_hr_eweight <= w_sel_eweight;
                r_ptr        <= (w_grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end else if (w_dp_accept) begin
                r_hr_valid <= 1'b0;
            end
            case ({w_req_hs, w_res_hs})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
            // Sticky: tag lost on a full FIFO, or a result nobody is waiting for.
            r_err <= r_err || (w_dp_accept && w_fifo_full && !w_res_hs)
                           || (dp_result_valid && w_fifo_empty);
        end
    end

    fifo #(.DATA_WIDTH(TAG_W), .DEPTH(MAX_INFLIGHT)) u_tag_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .i_push     (w_dp_accept),
        .i_push_dat (r_hr_tag),
        .i_pop      (w_res_hs),
        .o_head_dat (w_head_tag),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty)
    );

    always_comb begin
        res_valid = '0;
        if (dp_result_valid && !w_fifo_empty) res_valid[w_head_tag] = 1'b1;
    end

    assign dp_result_ready = !w_fifo_empty && res_ready[w_head_tag];
    assign w_res_hs        = dp_result_valid && dp_result_ready;
    assign res_mdata       = dp_mresult;
    assign res_edata       = dp_eresult;
    assign dp_mdata        = r_hr_mdata;
    assign dp_edata        = r_hr_edata;
    assign dp_mweight      = r_hr_mweight;
    assign dp_eweight      = r_hr_eweight;
    assign dp_data_valid   = r_hr_valid;
    assign dp_weight_valid = r_hr_valid;
    assign inflight        = r_inflight;
    assign err             = r_err;

endmodule

// File: tb/tb_mxint_dot_product_scheduler.sv
// Directed bench for the MXINT scheduler; the bench plays both the requesters and the shared unit.
module tb_mxint_dot_product_scheduler;
    localparam int NR = 4;
    localparam int BS = 6;

    logic        clk;
    logic        rst;
    logic [7:0]  req_mdata   [NR*BS];
    logic [7:0]  req_edata   [NR];
    logic [7:0]  req_mweight [NR*BS];
    logic [7:0]  req_eweight [NR];
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  dp_mdata    [BS];
    logic [7:0]  dp_edata;
    logic [7:0]  dp_mweight  [BS];
    logic [7:0]  dp_eweight;
    logic        dp_data_valid;
    logic        dp_weight_valid;
    logic        dp_data_ready;
    logic        dp_weight_ready;
    logic [18:0] dp_mresult;
    logic [8:0]  dp_eresult;
    logic        dp_result_valid;
    logic        dp_result_ready;
    logic [18:0] res_mdata;
    logic [8:0]  res_edata;
    logic [3:0]  res_valid;
    logic [3:0]  res_ready;
    logic [3:0]  inflight;
    logic        err;

    int total = 0;
    int bad   = 0;

    mxint_dot_product_scheduler dut (
        .clk(clk), .rst(rst),
        .req_mdata(req_mdata), .req_edata(req_edata),
        .req_mweight(req_mweight), .req_eweight(req_eweight),
        .req_valid(req_valid), .req_ready(req_ready),
        .dp_mdata(dp_mdata), .dp_edata(dp_edata),
        .dp_mweight(dp_mweight), .dp_eweight(dp_eweight),
        .dp_data_valid(dp_data_valid), .dp_weight_valid(dp_weight_valid),
        .dp_data_ready(dp_data_ready), .dp_weight_ready(dp_weight_ready),
        .dp_mresult(dp_mresult), .dp_eresult(dp_eresult),
        .dp_result_valid(dp_result_valid), .dp_result_ready(dp_result_ready),
        .res_mdata(res_mdata), .res_edata(res_edata),
        .res_valid(res_valid), .res_ready(res_ready),
        .inflight(inflight), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NR*BS; i++) begin
            req_mdata[i]   = 8'h00;
            req_mweight[i] = 8'h00;
        end
        for (int r = 0; r < NR; r++) begin
            req_edata[r]   = 8'h00;
            req_eweight[r] = 8'h00;
        end
        req_valid       = 4'b0000;
        dp_data_ready   = 1'b1;
        dp_weight_ready = 1'b1;
        dp_mresult      = '0;
        dp_eresult      = '0;
        dp_result_valid = 1'b0;
        res_ready       = 4'b1111;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        req_valid = 4'b1111;
        #3;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        total++; if (dp_data_valid !== 1'b0 || dp_weight_valid !== 1'b0) begin bad++; $display("FAIL reset_dp_valid got=%b%b exp=00", dp_data_valid, dp_weight_valid); end
        total++; if (res_valid !== 4'b0000) begin bad++; $display("FAIL reset_res_valid got=%b exp=0000", res_valid); end
        total++; if (dp_result_ready !== 1'b0) begin bad++; $display("FAIL reset_dp_result_ready got=%b exp=0", dp_result_ready); end
        total++; if (inflight !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL reset_inflight_err got=%0d/%b exp=0/0", inflight, err); end
        total++; if (dp_mdata[0] !== 8'h00 || dp_edata !== 8'h00) begin bad++; $display("FAIL reset_operands got=%h/%h exp=00/00", dp_mdata[0], dp_edata); end
        req_valid = 4'b0000;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int j = 0; j < BS; j++) begin
            req_mdata[2*BS+j]   = 8'(j + 1);
            req_mweight[2*BS+j] = 8'(10 + j);
        end
        req_edata[2]   = 8'd127;
        req_eweight[2] = 8'd127;
        req_valid      = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_req_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = 4'b0000;
        #1;
        total++; if (dp_data_valid !== 1'b1 || dp_weight_valid !== 1'b1) begin bad++; $display("FAIL single_dp_valid got=%b%b exp=11", dp_data_valid, dp_weight_valid); end
        total++; if (dp_edata !== 8'd127 || dp_eweight !== 8'd127) begin bad++; $display("FAIL single_exps got=%0d/%0d exp=127/127", dp_edata, dp_eweight); end
        total++; if (dp_mdata[3] !== 8'd4 || dp_mweight[5] !== 8'd15) begin bad++; $display("FAIL single_mants got=%0d/%0d exp=4/15", dp_mdata[3], dp_mweight[5]); end
        total++; if (inflight !== 4'd1) begin bad++; $display("FAIL single_inflight1 got=%0d exp=1", inflight); end
        tick();
        total++; if (dp_data_valid !== 1'b0) begin bad++; $display("FAIL single_dp_drop got=%b exp=0", dp_data_valid); end
        tick();
        tick();
        dp_result_valid = 1'b1;
        dp_mresult      = 19'd280;
        dp_eresult      = 9'd254;
        #1;
        total++; if (res_valid !== 4'b0100) begin bad++; $display("FAIL single_res_valid got=%b exp=0100", res_valid); end
        total++; if (res_mdata !== 19'd280 || res_edata !== 9'd254) begin bad++; $display("FAIL single_res_data got=%0d/%0d exp=280/254", res_mdata, res_edata); end
        total++; if (dp_result_ready !== 1'b1) begin bad++; $display("FAIL single_dp_result_ready got=%b exp=1", dp_result_ready); end
        tick();
        dp_result_valid = 1'b0;
        #1;
        total++; if (inflight !== 4'd0 || res_valid !== 4'b0000) begin bad++; $display("FAIL single_done got=%0d/%b exp=0/0000", inflight, res_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int r = 0; r < NR; r++) req_edata[r] = 8'(16 + r);
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            total++; if (req_ready !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL b2b_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << (k % 4)); end
            tick();
            total++; if (dp_edata !== 8'(16 + k % 4) || dp_data_valid !== 1'b1) begin bad++; $display("FAIL b2b_issue%0d got=%0d/%b exp=%0d/1", k, dp_edata, dp_data_valid, 16 + k % 4); end
        end
        #1;
        total++; if (req_ready !== 4'b0000 || inflight !== 4'd8) begin bad++; $display("FAIL cap_full got=%b/%0d exp=0000/8", req_ready, inflight); end
        tick();
        tick();
        total++; if (req_ready !== 4'b0000 || inflight !== 4'd8) begin bad++; $display("FAIL cap_hold got=%b/%0d exp=0000/8", req_ready, inflight); end
        dp_result_valid = 1'b1;
        dp_mresult      = 19'd100;
        #1;
        total++; if (res_valid !== 4'b0001 || dp_result_ready !== 1'b1) begin bad++; $display("FAIL cap_release got=%b/%b exp=0001/1", res_valid, dp_result_ready); end
        tick();
        dp_result_valid = 1'b0;
        #1;
        total++; if (req_ready !== 4'b0001 || inflight !== 4'd7) begin bad++; $display("FAIL cap_regrant got=%b/%0d exp=0001/7", req_ready, inflight); end
        tick();
        total++; if (req_ready !== 4'b0000 || inflight !== 4'd8 || dp_edata !== 8'd16) begin bad++; $display("FAIL cap_one_grant got=%b/%0d/%0d exp=0000/8/16", req_ready, inflight, dp_edata); end
        req_valid = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            dp_result_valid = 1'b1;
            dp_mresult      = 19'(200 + k);
            #1;
            total++; if (res_valid !== (4'b0001 << ((k + 1) % 4)) || res_mdata !== 19'(200 + k)) begin bad++; $display("FAIL b2b_owner%0d got=%b/%0d exp=%b/%0d", k, res_valid, res_mdata, 4'b0001 << ((k + 1) % 4), 200 + k); end
            tick();
        end
        dp_result_valid = 1'b0;
        #1;
        total++; if (inflight !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%0d/%b exp=0/0", inflight, err); end
    endtask

    task automatic test_hr_stall();
        do_reset();
        dp_data_ready = 1'b0;
        req_mdata[1*BS] = 8'h11;
        req_edata[1]    = 8'h21;
        req_valid       = 4'b0010;
        #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL stall_first got=%b exp=0010", req_ready); end
        tick();
        req_mdata[1*BS] = 8'h55;
        req_edata[1]    = 8'h66;
        req_edata[3]    = 8'h33;
        req_valid       = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (req_ready !== 4'b0000 || dp_data_valid !== 1'b1 || dp_mdata[0] !== 8'h11 || dp_edata !== 8'h21) begin bad++; $display("FAIL stall_hold%0d got=%b/%b/%h/%h exp=0000/1/11/21", k, req_ready, dp_data_valid, dp_mdata[0], dp_edata); end
            tick();
        end
        dp_data_ready = 1'b1;
        #1;
        total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL stall_refill_grant got=%b exp=1000", req_ready); end
        tick();
        req_valid = 4'b0000;
        total++; if (dp_edata !== 8'h33 || inflight !== 4'd2) begin bad++; $display("FAIL stall_refill got=%h/%0d exp=33/2", dp_edata, inflight); end
    endtask

    task automatic test_hol();
        do_reset();
        req_valid = 4'b0101;
        tick();
        tick();
        req_valid = 4'b0000;
        tick();
        res_ready       = 4'b1110;
        dp_result_valid = 1'b1;
        dp_mresult      = 19'd7;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++; if (dp_result_ready !== 1'b0 || res_valid !== 4'b0001 || res_mdata !== 19'd7 || err !== 1'b0 || inflight !== 4'd2) begin bad++; $display("FAIL hol_block%0d got=%b/%b/%0d/%b/%0d exp=0/0001/7/0/2", k, dp_result_ready, res_valid, res_mdata, err, inflight); end
            tick();
        end
        res_ready = 4'b1111;
        #1;
        total++; if (dp_result_ready !== 1'b1) begin bad++; $display("FAIL hol_release got=%b exp=1", dp_result_ready); end
        tick();
        total++; if (res_valid !== 4'b0100) begin bad++; $display("FAIL hol_next_owner got=%b exp=0100", res_valid); end
        tick();
        dp_result_valid = 1'b0;
        #1;
        total++; if (inflight !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL hol_done got=%0d/%b exp=0/0", inflight, err); end
    endtask

    task automatic test_err();
        do_reset();
        dp_result_valid = 1'b1;
        #1;
        total++; if (dp_result_ready !== 1'b0 || res_valid !== 4'b0000) begin bad++; $display("FAIL orphan_ack got=%b/%b exp=0/0000", dp_result_ready, res_valid); end
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL orphan_err got=%b exp=1", err); end
        dp_result_valid = 1'b0;
        tick();
        tick();
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
        rst = 1'b0;
        #1;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err); end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_hr_stall();
        test_hol();
        test_err();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
